mem_ctrl: RTL and testbench
===========================

Name: mem_ctrl

Overview:
- Memory controller between tomasulo_cpu and a single byte-wide synchronous RAM port.
- Arbitrates instruction fetch (inst_* port) against data load/store (mem_* port, driven by the LSB).
- Serialises each 32-bit access into byte transfers and assembles read words.
- Returns one-cycle completion pulses to the fetch unit and the LSB.

Parameters:
- ADDR_WIDTH, 17, width of the RAM byte address; CPU addresses are truncated to these low bits.

Ports:
- clk  in  1  system clock
- rst  in  1  reset: asynchronous, active-low
- flush  in  1  pipeline flush from commit; aborts an in-flight or pending instruction fetch
- inst_ce_i  in  1  instruction fetch request, held until inst_valid_o
- inst_addr_i  in  32  fetch byte address
- inst_o  out  32  fetched instruction, little-endian
- inst_valid_o  out  1  one-cycle pulse; inst_o valid
- mem_req_i  in  1  data request, held until mem_ready_o
- mem_we_i  in  1  1 = store, 0 = load
- mem_addr_i  in  32  data byte address
- mem_data_i  in  32  store data; lane i is written to addr+i
- mem_sel_i  in  4  byte-lane mask; lane i selects addr+i; must be 0001, 0011 or 1111
- mem_data_o  out  32  load data; unselected lanes are zero; LSB does sign extension
- mem_ready_o  out  1  one-cycle pulse; load data valid or store done
- ram_addr_o  out  ADDR_WIDTH  RAM byte address (registered)
- ram_dout_o  out  8  RAM write byte (registered)
- ram_wr_o  out  1  RAM write enable (registered)
- ram_din_i  in  8  RAM read byte; valid one cycle after ram_addr_o changes

Behaviour:
- Reset (rst=0, async): state IDLE. All outputs 0: inst_o, inst_valid_o, mem_data_o, mem_ready_o, ram_addr_o, ram_dout_o, ram_wr_o. Byte index and assembly buffer cleared. Reset mid-access abandons the access; no pulse is emitted.
- FSM states: IDLE, READ, WRITE, DONE.
- IDLE transitions:
  - mem_req_i=1 → READ or WRITE per mem_we_i. Data has priority over fetch.
  - else inst_ce_i=1 and flush=0 → READ tagged as fetch, nbytes=4.
  - Request fields (address, data, sel, we) are latched on the accepting edge T.
- Byte count: nbytes = 1 + index of the highest set bit of the latched sel.
- READ:
  - ram_addr_o = A+k is set at edge T+k, for k = 0..nbytes-1.
  - Byte k is captured from ram_din_i at edge T+k+2.
  - At edge T+nbytes+1: drive the assembled word (last byte taken directly from ram_din_i) and the matching pulse. Go to DONE.
  - Full word: pulse in cycle [T+5, T+6).
- WRITE:
  - At edge T+k, for k = 0..3: ram_addr_o = A+k, ram_dout_o = lane k, ram_wr_o = sel[k].
  - At edge T+4: ram_wr_o=0, mem_ready_o=1. Go to DONE.
  - Fixed 4 cycles, so timing is independent of sel.
- DONE:
  - The pulse is high for exactly this one cycle; no request is sampled here.
  - Next edge: pulse cleared, return to IDLE.
  - Requester must deassert req/ce on the edge where it sees the pulse, so the same request is never re-accepted.
- Address arithmetic: A+k is computed in ADDR_WIDTH bits and wraps modulo 2^ADDR_WIDTH.
- Flush:
  - During a fetch READ (or on the DONE edge of a fetch): return to IDLE next edge; inst_valid_o is never raised for that fetch.
  - Data accesses are never aborted. A store may already be committed; a flushed load's result is discarded by the LSB.
- Simultaneous inst_ce_i and mem_req_i in IDLE: data wins; the fetch is served after DONE if still requested.
- ram_wr_o is never 1 outside WRITE.
- mem_data_o and inst_o hold their last value until the next completion.

Decomposition:
- Shared package / params.v:
  - FSM state encodings MC_IDLE, MC_READ, MC_WRITE, MC_DONE (2 bits).
  - Constant RAM_ADDR_WIDTH=17.
  - Sel mask constants SEL_B=4'b0001, SEL_H=4'b0011, SEL_W=4'b1111.
- Sub-module: mem_byte_assembler, a byte-lane shift/assembly register with index counter. Used for reads and reusable by a future icache fill. FSM stays in mem_ctrl.

Test Plan:
- Fetch: RAM[0x100..0x103]=13,05,10,00; inst_ce_i=1, addr 0x100 at edge T → ram_addr 0x100..0x103 at T..T+3; inst_valid_o pulses at T+5 with inst_o=0x00100513; ram_wr_o stays 0.
- Load byte: sel=0001, addr 0x2003, RAM[0x2003]=0xF0 → mem_ready_o at T+2, mem_data_o=0x000000F0. Half (sel=0011, addr 0x2002) → pulse at T+3, upper 16 bits zero.
- Store half: data 0xDEADBEEF, sel=0011, addr 0x40 → RAM[0x40]=EF, RAM[0x41]=BE written; ram_wr_o=0 for k=2,3; mem_ready_o at T+4; RAM[0x42..0x43] unchanged.
- Arbitration: inst_ce_i and mem_req_i (load word) both rise in IDLE → load served first (ready at T+5); fetch accepted at T+7, inst_valid_o at T+12.
- Flush: fetch accepted at T, flush=1 at cycle T+2 → state IDLE at T+3, no inst_valid_o. A store in progress with flush asserted still completes all writes and pulses mem_ready_o.
- Reset/wrap: rst=0 asserted asynchronously mid-WRITE → ram_wr_o drops immediately, outputs 0. Word load at 0x1FFFE → ram_addr sequence 1FFFE, 1FFFF, 00000, 00001.

Source files
------------

// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the byte-serial memory controller: FSM encoding,
// RAM address width and the legal byte-lane masks.
package mem_ctrl_pkg;

  localparam int unsigned RAM_ADDR_WIDTH = 17;

  typedef enum logic [1:0] {
    MC_IDLE  = 2'd0,
    MC_READ  = 2'd1,
    MC_WRITE = 2'd2,
    MC_DONE  = 2'd3
  } mc_state_e;

  localparam logic [3:0] SEL_B = 4'b0001;
  localparam logic [3:0] SEL_H = 4'b0011;
  localparam logic [3:0] SEL_W = 4'b1111;

  // Transfer length is one past the highest selected lane.
  function automatic logic [2:0] sel_nbytes(input logic [3:0] sel);
    logic [2:0] n;
    case (sel)
      SEL_B:   n = 3'd1;
      SEL_H:   n = 3'd2;
      SEL_W:   n = 3'd4;
      default: begin
        if (sel[3])      n = 3'd4;
        else if (sel[2]) n = 3'd3;
        else if (sel[1]) n = 3'd2;
        else             n = 3'd1;
      end
    endcase
    return n;
  endfunction

endpackage

// File: rtl/mem_byte_assembler.sv
// Byte-lane assembly register: captures successive bytes into lanes 0,1,2...
// and offers the word with the current input byte merged at the next lane.
module mem_byte_assembler (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr_i,
  input  logic        cap_i,
  input  logic [7:0]  byte_i,
  output logic [31:0] merged_o
);

  logic [31:0] word_q;
  logic [1:0]  idx_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_q <= '0;
      idx_q  <= '0;
    end else if (clr_i) begin
      word_q <= '0;
      idx_q  <= '0;
    end else if (cap_i) begin
      word_q[{idx_q, 3'b000} +: 8] <= byte_i;
      idx_q                        <= idx_q + 2'd1;
    end
  end

  always_comb begin
    merged_o                        = word_q;
    merged_o[{idx_q, 3'b000} +: 8]  = byte_i;
  end

endmodule

// File: rtl/mem_ctrl.sv
// Memory controller: arbitrates fetch vs. load/store onto one byte-wide
// synchronous RAM port, serialising 32-bit accesses into byte transfers.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = RAM_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  inst_ce_i,
  input  logic [31:0]           inst_addr_i,
  output logic [31:0]           inst_o,
  output logic                  inst_valid_o,
  input  logic                  mem_req_i,
  input  logic                  mem_we_i,
  input  logic [31:0]           mem_addr_i,
  input  logic [31:0]           mem_data_i,
  input  logic [3:0]            mem_sel_i,
  output logic [31:0]           mem_data_o,
  output logic                  mem_ready_o,
  output logic [ADDR_WIDTH-1:0] ram_addr_o,
  output logic [7:0]            ram_dout_o,
  output logic                  ram_wr_o,
  input  logic [7:0]            ram_din_i
);

  mc_state_e             state_q, state_d;
  logic [2:0]            cnt_q, cnt_d;
  logic [2:0]            step;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]           data_q, data_d;
  logic [3:0]            sel_q, sel_d;
  logic [2:0]            nbytes_q, nbytes_d;
  logic                  fetch_q, fetch_d;

  logic [31:0]           inst_q, inst_d;
  logic                  inst_valid_q, inst_valid_d;
  logic [31:0]           mem_data_q, mem_data_d;
  logic                  mem_ready_q, mem_ready_d;
  logic [ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;
  logic [7:0]            ram_dout_q, ram_dout_d;
  logic                  ram_wr_q, ram_wr_d;

  logic                  asm_clr, asm_cap;
  logic [31:0]           asm_word;
  logic                  unused_bits;

  assign unused_bits = ^{inst_addr_i[31:ADDR_WIDTH], mem_addr_i[31:ADDR_WIDTH],
                         data_q[7:0], sel_q[0]};

  mem_byte_assembler u_asm (
    .clk      (clk),
    .rst_n    (rst),
    .clr_i    (asm_clr),
    .cap_i    (asm_cap),
    .byte_i   (ram_din_i),
    .merged_o (asm_word)
  );

  // step = edges elapsed since the accepting edge T
  assign step = cnt_q + 3'd1;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q + 3'd1;
    addr_d       = addr_q;
    data_d       = data_q;
    sel_d        = sel_q;
    nbytes_d     = nbytes_q;
    fetch_d      = fetch_q;
    inst_d       = inst_q;
    inst_valid_d = 1'b0;
    mem_data_d   = mem_data_q;
    mem_ready_d  = 1'b0;
    ram_addr_d   = ram_addr_q;
    ram_dout_d   = ram_dout_q;
    ram_wr_d     = 1'b0;
    asm_clr      = 1'b0;
    asm_cap      = 1'b0;

    case (state_q)
      MC_IDLE: begin
        cnt_d = '0;
        if (mem_req_i) begin
          addr_d     = mem_addr_i[ADDR_WIDTH-1:0];
          data_d     = mem_data_i;
          sel_d      = mem_sel_i;
          nbytes_d   = sel_nbytes(mem_sel_i);
          fetch_d    = 1'b0;
          ram_addr_d = mem_addr_i[ADDR_WIDTH-1:0];
          asm_clr    = 1'b1;
          if (mem_we_i) begin
            ram_dout_d = mem_data_i[7:0];
            ram_wr_d   = mem_sel_i[0];
            state_d    = MC_WRITE;
          end else begin
            state_d    = MC_READ;
          end
        end else if (inst_ce_i && !flush) begin
          addr_d     = inst_addr_i[ADDR_WIDTH-1:0];
          sel_d      = SEL_W;
          nbytes_d   = 3'd4;
          fetch_d    = 1'b1;
          ram_addr_d = inst_addr_i[ADDR_WIDTH-1:0];
          asm_clr    = 1'b1;
          state_d    = MC_READ;
        end
      end

      MC_READ: begin
        if (fetch_q && flush) begin
          state_d = MC_IDLE;
        end else begin
          if (step < nbytes_q)
            ram_addr_d = addr_q + ADDR_WIDTH'(step);
          // RAM data lags the address by two edges; the final byte bypasses the buffer
          if (step >= 3'd2 && step <= nbytes_q)
            asm_cap = 1'b1;
          if (step == nbytes_q + 3'd1) begin
            if (fetch_q) begin
              inst_d       = asm_word;
              inst_valid_d = 1'b1;
            end else begin
              mem_data_d   = asm_word;
              mem_ready_d  = 1'b1;
            end
            state_d = MC_DONE;
          end
        end
      end

      MC_WRITE: begin
        if (step < 3'd4) begin
          ram_addr_d = addr_q + ADDR_WIDTH'(step);
          ram_dout_d = data_q[{step[1:0], 3'b000} +: 8];
          ram_wr_d   = sel_q[step[1:0]];
        end else begin
          mem_ready_d = 1'b1;
          state_d     = MC_DONE;
        end
      end

      MC_DONE: begin
        state_d = MC_IDLE;
      end

      default: state_d = MC_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= MC_IDLE;
      cnt_q        <= '0;
      addr_q       <= '0;
      data_q       <= '0;
      sel_q        <= '0;
      nbytes_q     <= '0;
      fetch_q      <= 1'b0;
      inst_q       <= '0;
      inst_valid_q <= 1'b0;
      mem_data_q   <= '0;
      mem_ready_q  <= 1'b0;
      ram_addr_q   <= '0;
      ram_dout_q   <= '0;
      ram_wr_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      sel_q        <= sel_d;
      nbytes_q     <= nbytes_d;
      fetch_q      <= fetch_d;
      inst_q       <= inst_d;
      inst_valid_q <= inst_valid_d;
      mem_data_q   <= mem_data_d;
      mem_ready_q  <= mem_ready_d;
      ram_addr_q   <= ram_addr_d;
      ram_dout_q   <= ram_dout_d;
      ram_wr_q     <= ram_wr_d;
    end
  end

  assign inst_o       = inst_q;
  assign inst_valid_o = inst_valid_q;
  assign mem_data_o   = mem_data_q;
  assign mem_ready_o  = mem_ready_q;
  assign ram_addr_o   = ram_addr_q;
  assign ram_dout_o   = ram_dout_q;
  assign ram_wr_o     = ram_wr_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl with a behavioural byte-wide synchronous RAM.
module tb_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        inst_ce_i;
  logic [31:0] inst_addr_i;
  logic [31:0] inst_o;
  logic        inst_valid_o;
  logic        mem_req_i;
  logic        mem_we_i;
  logic [31:0] mem_addr_i;
  logic [31:0] mem_data_i;
  logic [3:0]  mem_sel_i;
  logic [31:0] mem_data_o;
  logic        mem_ready_o;
  logic [16:0] ram_addr_o;
  logic [7:0]  ram_dout_o;
  logic        ram_wr_o;
  logic [7:0]  ram_din_i;

  logic [7:0]  ram [0:131071];
  logic        pl_we;
  logic [16:0] pl_addr;
  logic [7:0]  pl_data;

  int checks = 0;
  int errors = 0;

  mem_ctrl #(.ADDR_WIDTH(17)) dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .inst_ce_i    (inst_ce_i),
    .inst_addr_i  (inst_addr_i),
    .inst_o       (inst_o),
    .inst_valid_o (inst_valid_o),
    .mem_req_i    (mem_req_i),
    .mem_we_i     (mem_we_i),
    .mem_addr_i   (mem_addr_i),
    .mem_data_i   (mem_data_i),
    .mem_sel_i    (mem_sel_i),
    .mem_data_o   (mem_data_o),
    .mem_ready_o  (mem_ready_o),
    .ram_addr_o   (ram_addr_o),
    .ram_dout_o   (ram_dout_o),
    .ram_wr_o     (ram_wr_o),
    .ram_din_i    (ram_din_i)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (pl_we)         ram[pl_addr]    <= pl_data;
    else if (ram_wr_o) ram[ram_addr_o] <= ram_dout_o;
    ram_din_i <= ram[ram_addr_o];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic poke(input logic [16:0] a, input logic [7:0] d);
    pl_addr = a;
    pl_data = d;
    pl_we   = 1'b1;
    tick();
    pl_we   = 1'b0;
  endtask

  task automatic req(input logic we, input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] s);
    mem_req_i  = 1'b1;
    mem_we_i   = we;
    mem_addr_i = a;
    mem_data_i = d;
    mem_sel_i  = s;
  endtask

  initial begin
    rst = 1'b0; flush = 1'b0; inst_ce_i = 1'b0; inst_addr_i = '0;
    mem_req_i = 1'b0; mem_we_i = 1'b0; mem_addr_i = '0; mem_data_i = '0;
    mem_sel_i = '0; pl_we = 1'b0; pl_addr = '0; pl_data = '0;

    poke(17'h00100, 8'h13); poke(17'h00101, 8'h05);
    poke(17'h00102, 8'h10); poke(17'h00103, 8'h00);
    poke(17'h00104, 8'h93); poke(17'h00105, 8'h05);
    poke(17'h00106, 8'h20); poke(17'h00107, 8'h00);
    poke(17'h02002, 8'h7A); poke(17'h02003, 8'hF0);
    poke(17'h00040, 8'h11); poke(17'h00041, 8'h22);
    poke(17'h00042, 8'h33); poke(17'h00043, 8'h44);
    poke(17'h00300, 8'hA1); poke(17'h00301, 8'hB2);
    poke(17'h00302, 8'hC3); poke(17'h00303, 8'hD4);
    poke(17'h1FFFE, 8'h01); poke(17'h1FFFF, 8'h02);
    poke(17'h00000, 8'h03); poke(17'h00001, 8'h04);

    // reset state
    check("rst_inst", inst_o, 32'h0);
    check("rst_ivalid", {31'b0, inst_valid_o}, 32'h0);
    check("rst_mdata", mem_data_o, 32'h0);
    check("rst_ready", {31'b0, mem_ready_o}, 32'h0);
    check("rst_raddr", {15'b0, ram_addr_o}, 32'h0);
    check("rst_dout", {24'b0, ram_dout_o}, 32'h0);
    check("rst_wr", {31'b0, ram_wr_o}, 32'h0);
    rst = 1'b1;
    tick();

    // instruction fetch at 0x100
    inst_ce_i = 1'b1; inst_addr_i = 32'h0000_0100;
    for (int k = 0; k < 4; k++) begin
      tick();
      check("fetch_addr", {15'b0, ram_addr_o}, 32'h100 + k);
      check("fetch_wr", {31'b0, ram_wr_o}, 32'h0);
    end
    tick();
    check("fetch_early", {31'b0, inst_valid_o}, 32'h0);
    tick();
    check("fetch_valid", {31'b0, inst_valid_o}, 32'h1);
    check("fetch_inst", inst_o, 32'h0010_0513);
    check("fetch_noready", {31'b0, mem_ready_o}, 32'h0);
    inst_ce_i = 1'b0;
    tick();
    check("fetch_pulse_end", {31'b0, inst_valid_o}, 32'h0);

    // load byte at 0x2003: pulse at T+2
    req(1'b0, 32'h0000_2003, 32'h0, 4'b0001);
    tick();
    check("lb_addr", {15'b0, ram_addr_o}, 32'h2003);
    tick();
    check("lb_early", {31'b0, mem_ready_o}, 32'h0);
    tick();
    check("lb_ready", {31'b0, mem_ready_o}, 32'h1);
    check("lb_data", mem_data_o, 32'h0000_00F0);
    mem_req_i = 1'b0;
    tick();
    check("lb_pulse_end", {31'b0, mem_ready_o}, 32'h0);

    // load half at 0x2002: pulse at T+3
    req(1'b0, 32'h0000_2002, 32'h0, 4'b0011);
    tick();
    tick();
    check("lh_addr1", {15'b0, ram_addr_o}, 32'h2003);
    tick();
    check("lh_early", {31'b0, mem_ready_o}, 32'h0);
    tick();
    check("lh_ready", {31'b0, mem_ready_o}, 32'h1);
    check("lh_data", mem_data_o, 32'h0000_F07A);
    mem_req_i = 1'b0;
    tick();

    // store half at 0x40
    req(1'b1, 32'h0000_0040, 32'hDEAD_BEEF, 4'b0011);
    tick();
    check("sh_addr0", {15'b0, ram_addr_o}, 32'h40);
    check("sh_dout0", {24'b0, ram_dout_o}, 32'hEF);
    check("sh_wr0", {31'b0, ram_wr_o}, 32'h1);
    tick();
    check("sh_addr1", {15'b0, ram_addr_o}, 32'h41);
    check("sh_dout1", {24'b0, ram_dout_o}, 32'hBE);
    check("sh_wr1", {31'b0, ram_wr_o}, 32'h1);
    tick();
    check("sh_wr2", {31'b0, ram_wr_o}, 32'h0);
    tick();
    check("sh_wr3", {31'b0, ram_wr_o}, 32'h0);
    check("sh_noready3", {31'b0, mem_ready_o}, 32'h0);
    tick();
    check("sh_ready", {31'b0, mem_ready_o}, 32'h1);
    check("sh_wr4", {31'b0, ram_wr_o}, 32'h0);
    mem_req_i = 1'b0;
    tick();
    check("sh_ram40", {24'b0, ram[17'h40]}, 32'hEF);
    check("sh_ram41", {24'b0, ram[17'h41]}, 32'hBE);
    check("sh_ram42", {24'b0, ram[17'h42]}, 32'h33);
    check("sh_ram43", {24'b0, ram[17'h43]}, 32'h44);

    // arbitration: load word wins over fetch
    req(1'b0, 32'h0000_0300, 32'h0, 4'b1111);
    inst_ce_i = 1'b1; inst_addr_i = 32'h0000_0104;
    tick();
    check("arb_addr", {15'b0, ram_addr_o}, 32'h300);
    repeat (5) tick();
    check("arb_ready", {31'b0, mem_ready_o}, 32'h1);
    check("arb_data", mem_data_o, 32'hD4C3_B2A1);
    check("arb_novalid", {31'b0, inst_valid_o}, 32'h0);
    mem_req_i = 1'b0;
    tick();
    tick();
    check("arb_fetch_addr", {15'b0, ram_addr_o}, 32'h104);
    repeat (4) tick();
    check("arb_fetch_early", {31'b0, inst_valid_o}, 32'h0);
    tick();
    check("arb_fetch_valid", {31'b0, inst_valid_o}, 32'h1);
    check("arb_fetch_inst", inst_o, 32'h0020_0593);
    inst_ce_i = 1'b0;
    tick();

    // flush aborts fetch; controller idle again at T+3
    inst_ce_i = 1'b1; inst_addr_i = 32'h0000_0100;
    tick();
    check("fl_addr", {15'b0, ram_addr_o}, 32'h100);
    tick();
    tick();
    flush = 1'b1; inst_ce_i = 1'b0;
    tick();
    check("fl_novalid3", {31'b0, inst_valid_o}, 32'h0);
    flush = 1'b0;
    req(1'b0, 32'h0000_2003, 32'h0, 4'b0001);
    tick();
    check("fl_idle_accept", {15'b0, ram_addr_o}, 32'h2003);
    check("fl_novalid4", {31'b0, inst_valid_o}, 32'h0);
    tick();
    check("fl_novalid5", {31'b0, inst_valid_o}, 32'h0);
    tick();
    check("fl_lb_ready", {31'b0, mem_ready_o}, 32'h1);
    check("fl_lb_data", mem_data_o, 32'h0000_00F0);
    check("fl_novalid6", {31'b0, inst_valid_o}, 32'h0);
    check("fl_inst_held", inst_o, 32'h0020_0593);
    mem_req_i = 1'b0;
    tick();

    // store word under flush still completes
    req(1'b1, 32'h0000_0050, 32'h1234_5678, 4'b1111);
    flush = 1'b1;
    repeat (5) tick();
    check("fls_ready", {31'b0, mem_ready_o}, 32'h1);
    mem_req_i = 1'b0; flush = 1'b0;
    tick();
    check("fls_ram50", {24'b0, ram[17'h50]}, 32'h78);
    check("fls_ram51", {24'b0, ram[17'h51]}, 32'h56);
    check("fls_ram52", {24'b0, ram[17'h52]}, 32'h34);
    check("fls_ram53", {24'b0, ram[17'h53]}, 32'h12);

    // word load wrapping past the top of RAM
    req(1'b0, 32'h0001_FFFE, 32'h0, 4'b1111);
    tick();
    check("wrap_a0", {15'b0, ram_addr_o}, 32'h1FFFE);
    tick();
    check("wrap_a1", {15'b0, ram_addr_o}, 32'h1FFFF);
    tick();
    check("wrap_a2", {15'b0, ram_addr_o}, 32'h00000);
    tick();
    check("wrap_a3", {15'b0, ram_addr_o}, 32'h00001);
    tick();
    tick();
    check("wrap_ready", {31'b0, mem_ready_o}, 32'h1);
    check("wrap_data", mem_data_o, 32'h0403_0201);
    mem_req_i = 1'b0;
    tick();

    // asynchronous reset in the middle of a store
    req(1'b1, 32'h0000_0060, 32'hCAFE_F00D, 4'b1111);
    tick();
    tick();
    check("mid_wr_before", {31'b0, ram_wr_o}, 32'h1);
    #2;
    rst = 1'b0;
    #1;
    check("ar_wr", {31'b0, ram_wr_o}, 32'h0);
    check("ar_addr", {15'b0, ram_addr_o}, 32'h0);
    check("ar_dout", {24'b0, ram_dout_o}, 32'h0);
    check("ar_mdata", mem_data_o, 32'h0);
    check("ar_inst", inst_o, 32'h0);
    mem_req_i = 1'b0;
    tick();
    rst = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      check("ar_noready", {31'b0, mem_ready_o}, 32'h0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
